// File: rtl/os_timer_bank.sv
// rtl/os_timer_bank.sv - uptime counter plus CHANNELS tick-driven countdown timers with flags and irq
// Ports: clk, rst_n (asynchronous, active-low); reg_addr/reg_we/reg_re/reg_wdata are single-cycle
// register strobes from the mapper decode; reg_rdata is registered read data held until the next
// reg_re; irq is the registered OR of enabled channel flags; tick pulses once per divider period.
module os_timer_bank #(
    parameter int CLK_HZ   = 50000000,
    parameter int TICK_HZ  = 1000,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] reg_addr,
    input  logic       reg_we,
    input  logic       reg_re,
    input  logic [7:0] reg_wdata,
    output logic [7:0] reg_rdata,
    output logic       irq,
    output logic       tick
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DIV_W = $clog2(DIV);
    localparam int NB    = CNT_W / 8;

    logic [DIV_W-1:0]    div_cnt;
    logic [CNT_W-1:0]    uptime;
    logic [CNT_W-1:0]    up_snap;
    logic [CNT_W-1:0]    reload   [CHANNELS];
    logic [CNT_W-1:0]    count    [CHANNELS];
    logic [CNT_W-1:0]    cnt_snap [CHANNELS];
    logic [CHANNELS-1:0] en;
    logic [CHANNELS-1:0] periodic;
    logic [CHANNELS-1:0] irq_en;
    logic [CHANNELS-1:0] flag;

    logic [3:0]          page;
    logic [3:0]          off;
    logic [7:0]          rd_next;
    logic [CHANNELS-1:0] ch_sel;
    logic [CHANNELS-1:0] ctrl_wr;
    logic [CHANNELS-1:0] load;
    logic [CHANNELS-1:0] run;
    logic [CHANNELS-1:0] expire;
    logic [CHANNELS-1:0] per_eff;
    logic [CHANNELS-1:0] flag_clr;

    assign page = reg_addr[7:4];
    assign off  = reg_addr[3:0];
    assign tick = (div_cnt == DIV_W'(DIV - 1));

    // Zero-extend to 32 bits so bytes at or above CNT_W/8 read as 0.
    function automatic logic [7:0] byte_of(input logic [CNT_W-1:0] v, input logic [1:0] idx);
        logic [31:0] w;
        w = 32'(v);
        return w[8*idx +: 8];
    endfunction

    always_comb begin
        for (int n = 0; n < CHANNELS; n++) begin
            ch_sel[n]   = (page == 4'(n + 1));
            ctrl_wr[n]  = reg_we && ch_sel[n] && (off == 4'd8);
            load[n]     = ctrl_wr[n] && reg_wdata[0] && !en[n];
            // A ctrl write in a tick cycle decides whether that tick counts; a fresh load swallows it.
            run[n]      = tick && !load[n] && (ctrl_wr[n] ? reg_wdata[0] : en[n]);
            expire[n]   = run[n] && (count[n][CNT_W-1:1] == '0);
            per_eff[n]  = ctrl_wr[n] ? reg_wdata[1] : periodic[n];
            flag_clr[n] = reg_we && (((page == 4'd0) && (off == 4'd4) && reg_wdata[n]) ||
                                     (ch_sel[n] && (off == 4'd9) && reg_wdata[0]));
        end
    end

    always_comb begin
        rd_next = 8'h00;
        if (page == 4'd0) begin
            if (off == 4'd0)      rd_next = uptime[7:0];
            else if (off < 4'd4)  rd_next = byte_of(up_snap, off[1:0]);
            else if (off == 4'd4) rd_next = 8'(flag);
        end
        for (int n = 0; n < CHANNELS; n++) begin
            if (ch_sel[n]) begin
                case (off)
                    4'd0, 4'd1, 4'd2, 4'd3: rd_next = byte_of(reload[n], off[1:0]);
                    4'd4:                   rd_next = count[n][7:0];
                    4'd5, 4'd6, 4'd7:       rd_next = byte_of(cnt_snap[n], off[1:0]);
                    4'd8:                   rd_next = {5'd0, irq_en[n], periodic[n], en[n]};
                    4'd9:                   rd_next = {7'd0, flag[n]};
                    default:                rd_next = 8'h00;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            uptime    <= '0;
            up_snap   <= '0;
            reg_rdata <= '0;
            irq       <= 1'b0;
            en        <= '0;
            periodic  <= '0;
            irq_en    <= '0;
            flag      <= '0;
            for (int n = 0; n < CHANNELS; n++) begin
                reload[n]   <= '0;
                count[n]    <= '0;
                cnt_snap[n] <= '0;
            end
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) uptime <= uptime + CNT_W'(1);
            irq <= |(flag & irq_en);
            if (reg_re) begin
                reg_rdata <= rd_next;
                if ((page == 4'd0) && (off == 4'd0)) up_snap <= uptime;
            end
            for (int n = 0; n < CHANNELS; n++) begin
                if (reg_re && ch_sel[n] && (off == 4'd4)) cnt_snap[n] <= count[n];
                for (int b = 0; b < NB; b++) begin
                    if (reg_we && ch_sel[n] && (off == 4'(b))) reload[n][8*b +: 8] <= reg_wdata;
                end
                if (ctrl_wr[n]) begin
                    en[n]       <= reg_wdata[0];
                    periodic[n] <= reg_wdata[1];
                    irq_en[n]   <= reg_wdata[2];
                end
                // reload here is the pre-edge value, so a same-cycle reload write only affects the next reload.
                if (load[n]) begin
                    count[n] <= reload[n];
                end else if (expire[n]) begin
                    if (per_eff[n]) begin
                        count[n] <= reload[n];
                    end else begin
                        count[n] <= '0;
                        en[n]    <= 1'b0;
                    end
                end else if (run[n]) begin
                    count[n] <= count[n] - CNT_W'(1);
                end
                if (expire[n])        flag[n] <= 1'b1;
                else if (flag_clr[n]) flag[n] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_os_timer_bank.sv
// tb/tb_os_timer_bank.sv - directed and randomized self-checking bench for os_timer_bank
module tb_os_timer_bank;
    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int CH      = 2;
    localparam int CW      = 16;
    localparam int unsigned WRAP = 32'd1 << CW;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] reg_addr;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       irq;
    logic       tick;

    always #5 clk = ~clk;

    os_timer_bank #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .CHANNELS(CH),
        .CNT_W   (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .reg_addr (reg_addr),
        .reg_we   (reg_we),
        .reg_re   (reg_re),
        .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata),
        .irq      (irq),
        .tick     (tick)
    );

    int total  = 0;
    int passed = 0;
    int failed = 0;

    int unsigned m_div;
    int unsigned m_up;
    int unsigned m_up_snap;
    int unsigned m_rel   [CH];
    int unsigned m_cnt   [CH];
    int unsigned m_csnap [CH];
    bit          m_en    [CH];
    bit          m_per   [CH];
    bit          m_ie    [CH];
    bit          m_flag  [CH];
    bit [7:0]    m_rdata;
    bit          m_irq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_div = 0; m_up = 0; m_up_snap = 0; m_rdata = 8'h00; m_irq = 1'b0;
        for (int c = 0; c < CH; c++) begin
            m_rel[c] = 0; m_cnt[c] = 0; m_csnap[c] = 0;
            m_en[c] = 1'b0; m_per[c] = 1'b0; m_ie[c] = 1'b0; m_flag[c] = 1'b0;
        end
    endfunction

    function automatic bit [7:0] mread(input logic [7:0] a);
        int pg;
        int of;
        int c;
        int unsigned fl;
        pg = int'(a >> 4);
        of = int'(a & 8'h0F);
        if (pg == 0) begin
            if (of == 0) return 8'(m_up);
            if (of < 4)  return 8'(m_up_snap >> (8 * of));
            if (of == 4) begin
                fl = 0;
                for (int k = 0; k < CH; k++) if (m_flag[k]) fl += (32'd1 << k);
                return 8'(fl);
            end
            return 8'h00;
        end
        if (pg > CH) return 8'h00;
        c = pg - 1;
        if (of < 4)  return 8'(m_rel[c] >> (8 * of));
        if (of == 4) return 8'(m_cnt[c]);
        if (of < 8)  return 8'(m_csnap[c] >> (8 * (of - 4)));
        if (of == 8) return 8'(int'(m_en[c]) + 2 * int'(m_per[c]) + 4 * int'(m_ie[c]));
        if (of == 9) return 8'(m_flag[c]);
        return 8'h00;
    endfunction

    // Applies the effect of one rising clock edge, given the inputs presented during that cycle.
    function automatic void model_edge();
        bit          tk;
        bit          nirq;
        bit          fire;
        int          pg;
        int          of;
        int          c;
        int unsigned old_rel [CH];
        bit          loaded  [CH];
        bit          clr     [CH];
        tk   = (m_div == DIV - 1);
        pg   = int'(reg_addr >> 4);
        of   = int'(reg_addr & 8'h0F);
        nirq = 1'b0;
        for (int k = 0; k < CH; k++) begin
            old_rel[k] = m_rel[k];
            loaded[k]  = 1'b0;
            clr[k]     = 1'b0;
            nirq       = nirq | (m_flag[k] & m_ie[k]);
        end
        if (reg_re) begin
            m_rdata = mread(reg_addr);
            if (reg_addr == 8'h00) m_up_snap = m_up;
            if (pg >= 1 && pg <= CH && of == 4) m_csnap[pg-1] = m_cnt[pg-1];
        end
        if (reg_we) begin
            if (reg_addr == 8'h04) for (int k = 0; k < CH; k++) clr[k] = reg_wdata[k];
            if (pg >= 1 && pg <= CH) begin
                c = pg - 1;
                if (of < CW / 8) begin
                    m_rel[c] = (m_rel[c] & ~(32'hFF << (8 * of))) | (32'(reg_wdata) << (8 * of));
                end else if (of == 8) begin
                    loaded[c] = !m_en[c] && reg_wdata[0];
                    m_en[c]   = reg_wdata[0];
                    m_per[c]  = reg_wdata[1];
                    m_ie[c]   = reg_wdata[2];
                    if (loaded[c]) m_cnt[c] = old_rel[c];
                end else if (of == 9) begin
                    clr[c] = reg_wdata[0];
                end
            end
        end
        for (int k = 0; k < CH; k++) begin
            fire = 1'b0;
            if (tk && m_en[k] && !loaded[k]) begin
                if (m_cnt[k] > 1) begin
                    m_cnt[k] = m_cnt[k] - 1;
                end else begin
                    fire = 1'b1;
                    if (m_per[k]) m_cnt[k] = old_rel[k];
                    else begin
                        m_cnt[k] = 0;
                        m_en[k]  = 1'b0;
                    end
                end
            end
            if (fire)        m_flag[k] = 1'b1;
            else if (clr[k]) m_flag[k] = 1'b0;
        end
        if (tk) m_up = (m_up + 1) % WRAP;
        m_div = tk ? 0 : m_div + 1;
        m_irq = nirq;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("tick", 32'(tick), 32'(m_div == DIV - 1));
        check("irq", 32'(irq), 32'(m_irq));
        check("rdata", 32'(reg_rdata), 32'(m_rdata));
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        reg_addr  = a;
        reg_wdata = d;
        reg_we    = 1'b1;
        cycle();
        reg_we    = 1'b0;
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [7:0] exp, input string tag);
        reg_addr = a;
        reg_re   = 1'b1;
        cycle();
        reg_re   = 1'b0;
        check(tag, 32'(reg_rdata), 32'(exp));
    endtask

    task automatic rd(input logic [7:0] a);
        reg_addr = a;
        reg_re   = 1'b1;
        cycle();
        reg_re   = 1'b0;
    endtask

    task automatic wait_ticks(input int k, input string tag);
        int seen;
        int guard;
        bit t;
        seen  = 0;
        guard = 0;
        while (seen < k && guard < 4 * DIV * k) begin
            t = (m_div == DIV - 1);
            cycle();
            if (t) seen++;
            guard++;
        end
        check(tag, 32'(seen), 32'(k));
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        reg_we = 1'b0;
        reg_re = 1'b0;
        #1;
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rdata", 32'(reg_rdata), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int         g;
    int         kind;
    int         sel;
    logic [7:0] a;
    logic [7:0] d;

    initial begin
        rst_n     = 1'b0;
        reg_addr  = 8'h00;
        reg_we    = 1'b0;
        reg_re    = 1'b0;
        reg_wdata = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Divider phase and uptime after three ticks.
        for (int i = 1; i <= 30; i++) begin
            cycle();
            check("tick_phase", 32'(tick), 32'((i % 10) == 9));
        end
        rd_chk(8'h00, 8'h03, "uptime_b0");
        rd_chk(8'h01, 8'h00, "uptime_b1");

        // Channel 0 one-shot with irq.
        wr(8'h10, 8'h03);
        wr(8'h11, 8'h00);
        wr(8'h18, 8'h05);
        wait_ticks(3, "ch0_wait");
        check("irq_lag", 32'(irq), 32'd0);
        cycle();
        check("irq_rise", 32'(irq), 32'd1);
        rd_chk(8'h19, 8'h01, "ch0_status");
        rd_chk(8'h04, 8'h01, "flags_ch0");
        rd_chk(8'h18, 8'h04, "ch0_ctrl_en_clear");
        rd_chk(8'h14, 8'h00, "ch0_count_zero");
        wr(8'h19, 8'h01);
        check("irq_hold", 32'(irq), 32'd1);
        cycle();
        check("irq_fall", 32'(irq), 32'd0);

        // Channel 1 periodic, clear racing expiry.
        wr(8'h20, 8'h02);
        wr(8'h28, 8'h03);
        wait_ticks(2, "ch1_t2");
        rd_chk(8'h04, 8'h02, "ch1_flag_t2");
        wr(8'h04, 8'h02);
        rd_chk(8'h04, 8'h00, "ch1_cleared");
        wait_ticks(1, "ch1_t3");
        rd_chk(8'h04, 8'h00, "ch1_t3_noflag");
        g = 0;
        while (!tick && g < 4 * DIV) begin
            cycle();
            g++;
        end
        check("align_tick", 32'(tick), 32'd1);
        wr(8'h04, 8'h02);
        rd_chk(8'h04, 8'h02, "set_wins");
        wr(8'h28, 8'h00);
        wr(8'h29, 8'h01);

        // Multi-byte latch across a tick.
        g = 0;
        while (!(m_up == 255 && m_div == 0) && g < 5000) begin
            cycle();
            g++;
        end
        check("latch_reach", 32'(m_up), 32'd255);
        rd_chk(8'h00, 8'hFF, "latch_b0");
        wait_ticks(1, "latch_tick");
        rd_chk(8'h01, 8'h00, "latch_b1");
        rd_chk(8'h00, 8'h00, "uptime_live_wrap");
        rd_chk(8'h01, 8'h01, "uptime_b1_new");

        // Out-of-range bytes and channels.
        wr(8'h12, 8'hAA);
        wr(8'h13, 8'hAA);
        rd_chk(8'h12, 8'h00, "rel_b2");
        rd_chk(8'h13, 8'h00, "rel_b3");
        for (int o = 0; o < 10; o++) wr(8'(8'h30 + o), 8'($urandom));
        for (int o = 0; o < 10; o++) rd_chk(8'(8'h30 + o), 8'h00, "ch2_unmapped");
        for (int o = 0; o < 10; o++) rd(8'(8'h10 + o));
        for (int o = 0; o < 10; o++) rd(8'(8'h20 + o));

        // Randomized traffic against the model.
        for (int i = 0; i < 1200; i++) begin
            kind = int'($urandom_range(0, 9));
            sel  = int'($urandom_range(0, 9));
            if (sel < 2)      a = 8'($urandom_range(0, 4));
            else if (sel < 8) a = {4'($urandom_range(1, 2)), 4'($urandom_range(0, 9))};
            else              a = 8'($urandom_range(0, 255));
            d = 8'($urandom);
            if (a[7:4] == 4'd1 || a[7:4] == 4'd2) begin
                if (a[3:0] == 4'd0) d = 8'($urandom_range(0, 6));
                if (a[3:0] == 4'd1) d = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00;
            end
            if (kind < 4)      wr(a, d);
            else if (kind < 8) rd(a);
            else               cycle();
            repeat ($urandom_range(0, 3)) cycle();
        end

        // Asynchronous reset in the middle of a count.
        wr(8'h28, 8'h00);
        wr(8'h18, 8'h00);
        wr(8'h20, 8'h01);
        wr(8'h21, 8'h00);
        wr(8'h28, 8'h07);
        wr(8'h10, 8'h08);
        wr(8'h11, 8'h00);
        wr(8'h18, 8'h01);
        wait_ticks(3, "pre_rst_wait");
        rd_chk(8'h14, 8'h05, "pre_rst_count");
        check("pre_rst_irq", 32'(irq), 32'd1);
        do_reset();
        rd_chk(8'h14, 8'h00, "post_rst_count");
        rd_chk(8'h00, 8'h00, "post_rst_uptime");
        rd_chk(8'h18, 8'h00, "post_rst_ctrl");
        rd_chk(8'h04, 8'h00, "post_rst_flags");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
